// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART <-> ALU frame interface: state encoding and
// the ALU opcode set understood by the ALU and used by the benches.
package uart_alu_interface_pkg;

   localparam int NB_DATA_DEFAULT = 8;
   localparam int NB_OP_DEFAULT   = 6;

   // Frame-assembly / transmit sequencing states.
   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      CAPTURE = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   // ALU opcodes (low NB_OP bits of the third received byte).
   localparam logic [NB_OP_DEFAULT-1:0] OP_ADD = 6'h20;
   localparam logic [NB_OP_DEFAULT-1:0] OP_SUB = 6'h22;
   localparam logic [NB_OP_DEFAULT-1:0] OP_AND = 6'h24;
   localparam logic [NB_OP_DEFAULT-1:0] OP_OR  = 6'h25;
   localparam logic [NB_OP_DEFAULT-1:0] OP_XOR = 6'h26;
   localparam logic [NB_OP_DEFAULT-1:0] OP_NOR = 6'h27;
   localparam logic [NB_OP_DEFAULT-1:0] OP_SRA = 6'h03;
   localparam logic [NB_OP_DEFAULT-1:0] OP_SRL = 6'h02;

endpackage : uart_alu_interface_pkg

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from rx_uart, presents them to
// a combinational ALU, captures the result and fires one tx_uart transmission.
// An inter-byte timer returns a stalled partial frame to WAIT_A.
module uart_alu_interface
   import uart_alu_interface_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done_tick,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_tx_done_tick,
   output logic [NB_DATA-1:0] o_alu_data_a,
   output logic [NB_DATA-1:0] o_alu_data_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy
);

   // A zero timeout disables the timer; keep at least one bit so the
   // counter declaration stays legal in that configuration.
   localparam int NB_TIMER = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [NB_TIMER-1:0] TIMER_LAST =
      (TIMEOUT_CYCLES > 0) ? NB_TIMER'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [NB_TIMER-1:0] TIMER_MAX =
      (TIMEOUT_CYCLES > 0) ? NB_TIMER'(TIMEOUT_CYCLES) : '0;

   state_t               r_state;
   state_t               w_next_state;
   logic [NB_TIMER-1:0]  r_timer;
   logic                 w_timer_run;
   logic                 w_timeout;
   logic [NB_DATA-1:0]   r_data_a;
   logic [NB_DATA-1:0]   r_data_b;
   logic [NB_OP-1:0]     r_op;
   logic [NB_DATA-1:0]   r_tx_data;

   // The timer only runs while a partial frame is waiting for its next byte;
   // a byte arriving in the expiry cycle takes priority over the timeout.
   assign w_timer_run = (r_state == WAIT_B) || (r_state == WAIT_OP);
   assign w_timeout   = (TIMEOUT_CYCLES > 0) && w_timer_run &&
                        !i_rx_done_tick && (r_timer == TIMER_LAST);

   // State register.
   always_ff @(posedge i_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or process order.
      if (i_reset) r_state <= WAIT_A;
      else         r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so every path assigns the signal and
      // no latch is inferred.
      w_next_state = r_state;
      unique case (r_state)
         WAIT_A:  if (i_rx_done_tick) w_next_state = WAIT_B;
         WAIT_B: begin
            if (i_rx_done_tick) w_next_state = WAIT_OP;
            else if (w_timeout) w_next_state = WAIT_A;
         end
         WAIT_OP: begin
            if (i_rx_done_tick) w_next_state = CAPTURE;
            else if (w_timeout) w_next_state = WAIT_A;
         end
         CAPTURE: w_next_state = SEND;
         SEND:    w_next_state = WAIT_TX;
         WAIT_TX: if (i_tx_done_tick) w_next_state = WAIT_A;
         default: w_next_state = WAIT_A;
      endcase
   end

   // State-decoded outputs: single start pulse in SEND, busy while a result is in flight.
   always_comb begin
      o_tx_start = 1'b0;
      o_busy     = 1'b0;
      unique case (r_state)
         CAPTURE: o_busy = 1'b1;
         SEND: begin
            o_tx_start = 1'b1;
            o_busy     = 1'b1;
         end
         WAIT_TX: o_busy = 1'b1;
         default: begin
            o_tx_start = 1'b0;
            o_busy     = 1'b0;
         end
      endcase
   end

   // Inter-byte timer: cleared outside the byte-wait states and on every byte; saturating.
   always_ff @(posedge i_clock) begin
      if (i_reset || !w_timer_run || i_rx_done_tick) r_timer <= '0;
      else if (r_timer != TIMER_MAX)                 r_timer <= r_timer + NB_TIMER'(1);
   end

   // Operand/opcode capture and result capture; operands persist across timeouts.
   always_ff @(posedge i_clock) begin
      // NOTE: these are plain registers, not a memory, so they take the
      // synchronous reset and come up as zero on the ALU and tx_uart ports.
      if (i_reset) begin
         r_data_a  <= '0;
         r_data_b  <= '0;
         r_op      <= '0;
         r_tx_data <= '0;
      end else begin
         if (i_rx_done_tick) begin
            unique case (r_state)
               WAIT_A:  r_data_a <= i_rx_data;
               WAIT_B:  r_data_b <= i_rx_data;
               WAIT_OP: r_op     <= i_rx_data[NB_OP-1:0];
               default: ;
            endcase
         end
         if (r_state == CAPTURE) r_tx_data <= i_alu_result;
      end
   end

   assign o_alu_data_a = r_data_a;
   assign o_alu_data_b = r_data_b;
   assign o_alu_op     = r_op;
   assign o_tx_data    = r_tx_data;

endmodule : uart_alu_interface
